// File: rtl/spi_txn_sequencer.sv
// Two-requester round-robin burst sequencer for a master-mode SPI core.
// Define TIMEOUT_EN to add a watchdog on the BUSY waits (ERR pulse and burst drop).
module spi_txn_sequencer #(
  parameter logic [7:0] CTRL_CFG = 8'hE4,
  parameter int         TMO_CYC  = 255
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [1:0] REQ,
  input  logic [7:0] TX_DATA0,
  input  logic [7:0] TX_DATA1,
  input  logic [1:0] BYTE_VALID,
  input  logic [1:0] LAST,
  output logic [1:0] GNT,
  output logic       BYTE_READY,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       ERR,
  output logic       SPI_WRITE,
  output logic       SPI_READ,
  output logic [7:0] SPI_CONTROL,
  output logic [7:0] SPI_TX,
  input  logic [7:0] SPI_RX,
  input  logic [7:0] SPI_STATUS
);

  typedef enum logic [3:0] {
    IDLE, ARB, FETCH_TX, LOAD, WAIT_BUSY, WAIT_DONE, READ, CAPTURE, RELEASE
  } state_t;

  state_t      state, state_nxt;
  logic        rr_ptr, gidx, last_q;
  logic [1:0]  gnt_q;
  logic        busy, accept, arb_pick, tmo, in_burst;
  logic [7:0]  tx_data_p0, rx_data_p1;
  logic        vld_p1;

  assign busy     = SPI_STATUS[0];
  assign accept   = (state == FETCH_TX) && BYTE_VALID[gidx];
  assign arb_pick = REQ[rr_ptr] ? rr_ptr : ~rr_ptr;
  assign in_burst = (state inside {FETCH_TX, LOAD, WAIT_BUSY, WAIT_DONE, READ, CAPTURE});

`ifdef TIMEOUT_EN
  localparam int CNT_W = $clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             unused_bits;
  assign unused_bits = ^SPI_STATUS[7:1];

  // Counter restarts on every state change, so each wait gets its own budget
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)                                         tmo_cnt <= '0;
    else if (state != state_nxt)                     tmo_cnt <= '0;
    else if (state == WAIT_BUSY || state == WAIT_DONE) tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo = ((state == WAIT_BUSY && !busy) || (state == WAIT_DONE && busy)) &&
               (tmo_cnt == TMO_LAST);
`else
  logic unused_bits;
  assign unused_bits = ^{SPI_STATUS[7:1], (TMO_CYC != 0)};
  assign tmo = 1'b0;
`endif

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (|REQ) state_nxt = ARB;
      ARB:       state_nxt = (|REQ) ? FETCH_TX : IDLE;
      FETCH_TX:  if (accept) state_nxt = LOAD;
      LOAD:      state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (busy) state_nxt = WAIT_DONE; else if (tmo) state_nxt = RELEASE;
      WAIT_DONE: if (!busy) state_nxt = READ; else if (tmo) state_nxt = RELEASE;
      READ:      state_nxt = CAPTURE;
      CAPTURE:   state_nxt = last_q ? RELEASE : FETCH_TX;
      RELEASE:   state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Strobes and CONTROL decode straight from state so CLR clears them at once
  always_comb begin
    GNT         = in_burst ? gnt_q : 2'b00;
    BYTE_READY  = accept;
    SPI_WRITE   = (state == LOAD);
    SPI_READ    = (state == READ);
    SPI_CONTROL = in_burst ? CTRL_CFG : 8'h00;
    ERR         = tmo;
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      rr_ptr <= 1'b0;
      gidx   <= 1'b0;
      gnt_q  <= 2'b00;
      last_q <= 1'b0;
    end else begin
      if (state == ARB && (|REQ)) begin
        gidx  <= arb_pick;
        gnt_q <= arb_pick ? 2'b10 : 2'b01;
      end
      if (state == RELEASE) begin
        rr_ptr <= ~gidx;
        gnt_q  <= 2'b00;
      end
      if (accept) last_q <= LAST[gidx];
    end
  end

  // p0: transmit byte latched on accept
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR)         tx_data_p0 <= 8'h00;
    else if (accept) tx_data_p0 <= gidx ? TX_DATA1 : TX_DATA0;
  end

  // p1: received byte and its valid, launched from CAPTURE
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      rx_data_p1 <= 8'h00;
      vld_p1     <= 1'b0;
    end else begin
      vld_p1 <= (state == CAPTURE);
      if (state == CAPTURE) rx_data_p1 <= SPI_RX;
    end
  end

  assign SPI_TX   = tx_data_p0;
  assign RX_DATA  = rx_data_p1;
  assign RX_VALID = vld_p1;

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Randomized bench for spi_txn_sequencer: requester queues, a behavioural SPI core
// and a round-robin/burst reference model scoring every cycle.
module tb_spi_txn_sequencer;
`ifdef TIMEOUT_EN
  localparam int TMO     = 16;
  localparam int T1_BUSY = 12;
`else
  localparam int TMO     = 16;
  localparam int T1_BUSY = 20;
`endif

  logic       CLK = 1'b0;
  logic       CLR;
  logic [1:0] REQ, BYTE_VALID, LAST, GNT;
  logic [7:0] TX_DATA0, TX_DATA1, RX_DATA, SPI_CONTROL, SPI_TX, SPI_RX, SPI_STATUS;
  logic       BYTE_READY, RX_VALID, ERR, SPI_WRITE, SPI_READ;

  always #5 CLK = ~CLK;

  spi_txn_sequencer #(.CTRL_CFG(8'hE4), .TMO_CYC(TMO)) dut (
    .CLK(CLK), .CLR(CLR), .REQ(REQ), .TX_DATA0(TX_DATA0), .TX_DATA1(TX_DATA1),
    .BYTE_VALID(BYTE_VALID), .LAST(LAST), .GNT(GNT), .BYTE_READY(BYTE_READY),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .ERR(ERR), .SPI_WRITE(SPI_WRITE),
    .SPI_READ(SPI_READ), .SPI_CONTROL(SPI_CONTROL), .SPI_TX(SPI_TX),
    .SPI_RX(SPI_RX), .SPI_STATUS(SPI_STATUS)
  );

  int n_chk = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // requester byte queues: {last, data}
  logic [8:0] bq0[$], bq1[$];
  logic [7:0] exp_wr[$], exp_rx[$], resp_q[$];
  int         grant_log[$];
  bit         core_en = 1'b1, noise1 = 1'b0;
  int         busy_fix = 0, core_phase = 0, core_left = 0;
  logic [7:0] core_resp;
  logic       busy_r;
  bit         acc0, acc1, wr_now, pref, burst_err, last_acc_last, cur_w;
  logic [1:0] prev_gnt = 2'b00, prev_req = 2'b00;
  int cyc = 0, rx_cnt = 0, wr_cnt = 0, err_cnt = 0, err_cyc = 0, wr_cyc = 0;
  int burst_len = 0, burst_rx = 0, last_burst_len = 0, noise_bad = 0;

  task automatic monitor();
    bit w;
    acc0 = BYTE_READY && GNT[0] && BYTE_VALID[0];
    acc1 = BYTE_READY && GNT[1] && BYTE_VALID[1];
    wr_now = SPI_WRITE;
    if (BYTE_READY) check("brdy_src", 32'(|(GNT & BYTE_VALID)), 1);
    check("ctrl", SPI_CONTROL, (GNT != 2'b00) ? 8'hE4 : 8'h00);
    if (noise1 && GNT[1]) noise_bad++;
    if (SPI_WRITE) begin
      wr_cnt++; wr_cyc = cyc;
      if (exp_wr.size() == 0) check("wr_unexp", 1, 0);
      else check("spi_tx", SPI_TX, exp_wr.pop_front());
    end
    if (RX_VALID) begin
      rx_cnt++; burst_rx++;
      if (exp_rx.size() == 0) check("rx_unexp", 1, 0);
      else check("rx_data", RX_DATA, exp_rx.pop_front());
    end
    if (ERR) begin err_cnt++; err_cyc = cyc; burst_err = 1'b1; end
    if (GNT != prev_gnt) begin
      if (prev_gnt == 2'b00) begin
        w = (prev_req == 2'b11) ? pref : prev_req[1];
        check("gnt_rr", GNT, w ? 2'b10 : 2'b01);
        cur_w = GNT[1];
        grant_log.push_back(int'(GNT[1]));
        burst_len = 0; burst_rx = 0; burst_err = 1'b0;
      end else if (GNT == 2'b00) begin
        if (!burst_err) begin
          check("burst_rx", burst_rx, burst_len);
          check("burst_last", 32'(last_acc_last), 1);
        end
        last_burst_len = burst_len;
        pref = ~cur_w;
      end else check("gnt_switch", GNT, prev_gnt);
    end
    if (acc0 || acc1) begin
      burst_len++;
      if (acc0) begin exp_wr.push_back(bq0[0][7:0]); last_acc_last = bq0[0][8]; end
      else      begin exp_wr.push_back(bq1[0][7:0]); last_acc_last = bq1[0][8]; end
    end
    prev_gnt = GNT;
    prev_req = REQ;
  endtask

  task automatic drive();
    if (acc0 && bq0.size() != 0) void'(bq0.pop_front());
    if (acc1 && bq1.size() != 0) void'(bq1.pop_front());
    if (CLR) begin
      bq0.delete(); bq1.delete(); exp_wr.delete(); exp_rx.delete();
      core_phase = 0; busy_r = 1'b0;
    end else if (wr_now && core_en) begin
      core_phase = 1;
      core_left  = $urandom_range(0, 3);
      core_resp  = (resp_q.size() != 0) ? resp_q.pop_front() : 8'($urandom);
    end
    if (core_phase == 1) begin
      if (core_left == 0) begin
        busy_r = 1'b1; core_phase = 2;
        core_left = (busy_fix != 0) ? busy_fix : $urandom_range(1, 6);
        exp_rx.push_back(core_resp);
      end else core_left--;
    end else if (core_phase == 2) begin
      core_left--;
      if (core_left == 0) begin busy_r = 1'b0; core_phase = 0; end
    end
    SPI_RX     = (core_phase == 2) ? 8'($urandom) : core_resp;
    SPI_STATUS = {7'($urandom), busy_r};
    REQ        = {bq1.size() != 0, bq0.size() != 0};
    BYTE_VALID[0] = (bq0.size() != 0) && ($urandom_range(0, 3) != 0);
    TX_DATA0      = (bq0.size() != 0) ? bq0[0][7:0] : 8'($urandom);
    LAST[0]       = (bq0.size() != 0) ? bq0[0][8] : 1'($urandom);
    if (noise1) begin
      BYTE_VALID[1] = 1'($urandom); TX_DATA1 = 8'hEE; LAST[1] = 1'b1;
    end else begin
      BYTE_VALID[1] = (bq1.size() != 0) && ($urandom_range(0, 3) != 0);
      TX_DATA1      = (bq1.size() != 0) ? bq1[0][7:0] : 8'($urandom);
      LAST[1]       = (bq1.size() != 0) ? bq1[0][8] : 1'($urandom);
    end
    wr_now = 1'b0;
  endtask

  initial begin : drv
    REQ = 2'b00; BYTE_VALID = 2'b00; LAST = 2'b00; TX_DATA0 = 8'h00; TX_DATA1 = 8'h00;
    SPI_RX = 8'h00; SPI_STATUS = 8'h00; busy_r = 1'b0; core_resp = 8'h00;
    forever begin
      @(negedge CLK);
      cyc++;
      if (!CLR) monitor();
      else begin
        acc0 = 1'b0; acc1 = 1'b0; wr_now = 1'b0;
        prev_gnt = 2'b00; prev_req = 2'b00; pref = 1'b0;
      end
      @(posedge CLK); #1;
      drive();
    end
  end

  task automatic wait_idle();
    int n = 0, quiet = 0;
    while (quiet < 4 && n < 6000) begin
      @(negedge CLK); n++;
      if (bq0.size() == 0 && bq1.size() == 0 && GNT == 2'b00 && core_phase == 0 &&
          !RX_VALID && REQ == 2'b00) quiet++;
      else quiet = 0;
    end
    check("idle_tmo", 32'(n < 6000), 1);
  endtask

  task automatic do_reset();
    @(negedge CLK); #2 CLR = 1'b1;
    repeat (3) @(negedge CLK);
    #2 CLR = 1'b0;
  endtask

  int rx0, wr0, g0, tot, e0, n;

  initial begin : main
    CLR = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_gnt", GNT, 0);        check("rst_brdy", BYTE_READY, 0);
    check("rst_rxv", RX_VALID, 0);   check("rst_err", ERR, 0);
    check("rst_wr", SPI_WRITE, 0);   check("rst_rd", SPI_READ, 0);
    check("rst_ctrl", SPI_CONTROL, 0); check("rst_tx", SPI_TX, 0);
    check("rst_rxd", RX_DATA, 0);
    #1 CLR = 1'b0;

    // single byte, long BUSY
    busy_fix = T1_BUSY; resp_q.push_back(8'h4D); rx0 = rx_cnt; wr0 = wr_cnt;
    bq0.push_back({1'b1, 8'h50});
    wait_idle();
    check("t1_wr", wr_cnt - wr0, 1); check("t1_rx", rx_cnt - rx0, 1);
    check("t1_rxd", RX_DATA, 8'h4D); check("t1_gnt", GNT, 0); check("t1_ctrl", SPI_CONTROL, 0);

    // two-byte burst from requester 1
    busy_fix = 0; resp_q.push_back(8'h6C); resp_q.push_back(8'h4C); rx0 = rx_cnt; wr0 = wr_cnt;
    bq1.push_back({1'b0, 8'h54}); bq1.push_back({1'b1, 8'h6C});
    wait_idle();
    check("t2_wr", wr_cnt - wr0, 2); check("t2_rx", rx_cnt - rx0, 2);
    check("t2_len", last_burst_len, 2); check("t2_who", grant_log[$], 1);
    check("t2_rxd", RX_DATA, 8'h4C);

    // contention straight after reset
    do_reset(); g0 = grant_log.size();
    bq0.push_back({1'b1, 8'h11}); bq0.push_back({1'b0, 8'h21}); bq0.push_back({1'b1, 8'h22});
    bq1.push_back({1'b0, 8'h31}); bq1.push_back({1'b1, 8'h32}); bq1.push_back({1'b1, 8'h41});
    wait_idle();
    check("t3_n", grant_log.size() - g0, 4);
    if (grant_log.size() - g0 == 4)
      for (int i = 0; i < 4; i++) check("t3_order", grant_log[g0 + i], i % 2);

    // reset during WAIT_DONE
    busy_fix = 30; bq0.push_back({1'b1, 8'h77}); n = 0;
    while (!SPI_STATUS[0] && n < 200) begin @(negedge CLK); n++; end
    check("t4_busy_seen", 32'(n < 200), 1);
    repeat (5) @(negedge CLK);
    rx0 = rx_cnt;
    #2 CLR = 1'b1;
    #1;
    check("t4_wr", SPI_WRITE, 0); check("t4_rd", SPI_READ, 0);
    check("t4_gnt", GNT, 0);      check("t4_ctrl", SPI_CONTROL, 0);
    repeat (3) @(negedge CLK);
    #2 CLR = 1'b0;
    busy_fix = 0;
    repeat (10) @(negedge CLK);
    check("t4_norx", rx_cnt - rx0, 0);
    bq0.push_back({1'b1, 8'h9A});
    wait_idle();
    check("t4_after", rx_cnt - rx0, 1);

    // requester 1 BYTE_VALID noise while requester 0 owns the core
    noise1 = 1'b1; noise_bad = 0; rx0 = rx_cnt;
    bq0.push_back({1'b0, 8'hA1}); bq0.push_back({1'b0, 8'hA2}); bq0.push_back({1'b1, 8'hA3});
    wait_idle();
    noise1 = 1'b0;
    check("t5_len", last_burst_len, 3); check("t5_rx", rx_cnt - rx0, 3);
    check("t5_who", grant_log[$], 0);   check("t5_g1", noise_bad, 0);

    // randomized bursts on both requesters
    rx0 = rx_cnt; tot = 0;
    for (int k = 0; k < 24; k++) begin
      int len = $urandom_range(1, 4);
      bit r = 1'($urandom);
      for (int b = 0; b < len; b++) begin
        logic [8:0] e;
        e = {b == len - 1, 8'($urandom)};
        if (r) bq1.push_back(e); else bq0.push_back(e);
      end
      tot += len;
    end
    wait_idle();
    check("t6_rx", rx_cnt - rx0, tot);

    // core never raises BUSY
    core_en = 1'b0; rx0 = rx_cnt; e0 = err_cnt;
    bq0.push_back({1'b1, 8'h5A});
`ifdef TIMEOUT_EN
    wait_idle();
    check("t7_err", err_cnt - e0, 1);
    check("t7_when", err_cyc - wr_cyc, TMO);
    check("t7_norx", rx_cnt - rx0, 0);
    check("t7_gnt", GNT, 0);
`else
    repeat (1000) @(negedge CLK);
    check("t7_stuck", GNT, 2'b01);
    check("t7_ctrl", SPI_CONTROL, 8'hE4);
    check("t7_noerr", err_cnt - e0, 0);
    check("t7_norx", rx_cnt - rx0, 0);
    do_reset();
    check("err_never", err_cnt, 0);
`endif
    core_en = 1'b1;
    repeat (4) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_txn_sequencer.md
Name: spi_txn_sequencer

Overview:
- Two-requester controller for one master-mode SPI core.
- Arbitrates bursts round-robin and drives the core's WRITE/READ strobes and CONTROL byte.
- Tracks the core's STATUS busy flag and returns each received byte to the granted requester.
- Sits between the local bus clients and the SPI core in master mode; the SPI pins are untouched here.

Parameters:
- CTRL_CFG, 8'hE4: CONTROL byte applied to the core while a burst is granted.
- TMO_CYC, 255: watchdog limit in CLK cycles; used only with TIMEOUT_EN.

Ports:
- CLK  in  1  system clock, rising edge.
- CLR  in  1  asynchronous active-high reset.
- REQ  in  2  per-requester burst request; held high for the whole burst.
- TX_DATA0  in  8  requester 0 transmit byte.
- TX_DATA1  in  8  requester 1 transmit byte.
- BYTE_VALID  in  2  per-requester "TX_DATAn holds next byte".
- LAST  in  2  per-requester "this byte ends the burst"; sampled with BYTE_VALID.
- GNT  out  2  one-hot grant.
- BYTE_READY  out  1  byte accepted from the granted requester (1-cycle pulse).
- RX_DATA  out  8  received byte.
- RX_VALID  out  1  RX_DATA valid (1-cycle pulse).
- ERR  out  1  abort pulse.
- SPI_WRITE  out  1  core write strobe.
- SPI_READ  out  1  core read strobe.
- SPI_CONTROL  out  8  core CONTROL.
- SPI_TX  out  8  core INCOMING_DATA.
- SPI_RX  in  8  core OUTCOMING_DATA.
- SPI_STATUS  in  8  core STATUS; bit0 = BUSY, other bits ignored.

Behaviour:
- Reset (CLR high, async): state=IDLE, rr_ptr=0. GNT, BYTE_READY, RX_VALID, ERR, SPI_WRITE and SPI_READ are 0. SPI_CONTROL=8'h00, SPI_TX=8'h00, RX_DATA=8'h00.
- IDLE: SPI_CONTROL=8'h00. If any REQ is high, go to ARB.
- ARB: one cycle.
  - Grant REQ[rr_ptr] if set, else the other requester.
  - Set GNT, then go to FETCH_TX.
  - If REQ has dropped to 0, return to IDLE.
- FETCH_TX:
  - SPI_CONTROL=CTRL_CFG from this state until release.
  - Wait for BYTE_VALID of the granted requester.
  - On accept: BYTE_READY=1 for that cycle, latch TX_DATAn into SPI_TX, latch LAST into last_q, go to LOAD.
- LOAD: SPI_WRITE=1 for exactly one cycle, then go to WAIT_BUSY.
- WAIT_BUSY: wait for SPI_STATUS[0]=1, then go to WAIT_DONE.
- WAIT_DONE: wait for SPI_STATUS[0]=0, then go to READ.
- READ: SPI_READ=1 for one cycle, then go to CAPTURE.
- CAPTURE: RX_DATA<=SPI_RX, RX_VALID=1 for one cycle.
  - If last_q=1, go to RELEASE; otherwise go to FETCH_TX.
- RELEASE: GNT=0, SPI_CONTROL=8'h00, rr_ptr<=~granted index, go to IDLE.
- Per-byte latency: from BYTE_READY to RX_VALID is 4 cycles plus the core's busy time.
- Grant changes only in ARB and RELEASE. Dropping REQ mid-burst has no effect; the burst ends only on a LAST byte.
- Simultaneous requests: rr_ptr decides. After reset, requester 0 wins the first tie.
- Back-to-back requests: after RELEASE, a requester that still holds REQ is re-arbitrated. A pending other requester always wins the next ARB.
- BYTE_VALID from the non-granted requester is ignored; its BYTE_READY is never pulsed.
- A BUSY pulse shorter than one CLK cycle is missed. The core must hold BUSY for at least 1 cycle.
- CLR mid-burst aborts immediately. The SPI strobes and CONTROL return to their idle values asynchronously.

Optional Feature:
- Macro TIMEOUT_EN.
- Defined:
  - A cycle counter is cleared on entry to WAIT_BUSY and WAIT_DONE.
  - If the counter reaches TMO_CYC while still waiting: ERR=1 for one cycle, no RX_VALID, go to RELEASE. The burst is dropped.
- Undefined: no counter; waits are unbounded; ERR is tied to 0.

Test Plan:
- Single byte: REQ=2'b01, TX_DATA0=8'h50, LAST[0]=1, core BUSY for 20 cycles, SPI_RX=8'h4D.
  - Required: one SPI_WRITE with SPI_TX=8'h50; SPI_CONTROL=8'hE4 during the burst.
  - Then RX_DATA=8'h4D with RX_VALID once, GNT returns to 0, SPI_CONTROL=8'h00.
- Two-byte burst: requester 1 sends 8'h54 then 8'h6C (LAST on the second), SPI_RX returns 8'h6C, 8'h4C.
  - Required: two WRITE/READ pairs and RX_VALID twice in order.
  - GNT=2'b10 held throughout; no IDLE between the bytes.
- Contention: both REQ high from reset.
  - Required: GNT=01 first; after its LAST byte, GNT=10.
  - With both still high, the next grant is 01 again (alternation).
- Reset mid-burst: assert CLR during WAIT_DONE.
  - Required: same cycle SPI_WRITE=SPI_READ=0, GNT=0, SPI_CONTROL=8'h00, RX_VALID never fires.
  - After release, a new REQ=01 completes normally.
- With TIMEOUT_EN and TMO_CYC=16, BUSY never asserts.
  - Required: ERR pulses on the 16th waiting cycle, GNT clears, no RX_VALID.
  - Without the macro, the FSM stays in WAIT_BUSY for 1000 cycles and ERR stays 0.
- Non-granted BYTE_VALID: requester 1 toggles BYTE_VALID while requester 0 is granted.
  - Required: no BYTE_READY toward requester 1; SPI_TX carries only requester 0 data.
